i2c_master_write: RTL and testbench

//  Synthesizable I2C master that runs a fixed-length write transaction: START, 7-bit address + R/W bit,

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_clk_gen.sv | 44 ++++
 rtl/i2c_master_write.sv | 184 ++++++++++++++++++
 tb/tb_i2c_master_write.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write master: FSM state codes, bit-phase codes
// and the quarter-period divider helper.
package i2c_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_ACK   = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;

    // Quarter phases within one SCL bit period
    localparam logic [1:0] PH_0 = 2'd0;   // SCL low, SDA updated
    localparam logic [1:0] PH_1 = 2'd1;   // SCL low
    localparam logic [1:0] PH_2 = 2'd2;   // SCL high
    localparam logic [1:0] PH_3 = 2'd3;   // SCL high, ACK sampled at its end

    // System clocks per quarter SCL period (clk in MHz, SCL in kHz)
    function automatic int quarter_cycles(input int clk_mhz, input int scl_khz);
        return (clk_mhz * 1000) / (scl_khz * 4);
    endfunction

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-period tick generator plus 2-bit phase counter. Both counters sit at
// zero while disabled, so the first quarter after enable is a full Q cycles.
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int Q = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int CW = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [CW-1:0] Q_LAST = CW'(Q - 1);

    // A divider of less than two cycles cannot produce distinct quarter phases
    generate
        if (Q < 2) begin : g_q_too_small
            $fatal(1, "i2c_clk_gen: quarter period Q must be at least 2 clk cycles");
        end
    endgenerate

    logic [CW-1:0] tick_cnt_reg;
    logic [1:0]    phase_reg;

    // Count clk cycles within a quarter and advance the phase at each quarter end
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            tick_cnt_reg <= '0;
            phase_reg    <= PH_0;
        end else if (tick_cnt_reg == Q_LAST) begin
            tick_cnt_reg <= '0;
            phase_reg    <= phase_reg + 2'd1;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + CW'(1);
        end
    end

    assign tick  = enable && (tick_cnt_reg == Q_LAST);
    assign phase = phase_reg;

endmodule

// File: rtl/i2c_master_write.sv
// Fixed-length I2C write master: START, {addr, access}, NUM_BYTE data bytes MSB
// first, each followed by an ACK slot, then STOP. A NACK aborts straight to STOP.
module i2c_master_write
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ     = 50,
    parameter int I2C_CLK_FREQ = 100,
    parameter int NUM_BYTE     = 4,
    parameter int BYTE_SIZE    = 8,
    parameter int DATA_WIDTH   = NUM_BYTE * BYTE_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [BYTE_SIZE-2:0]  addr,
    input  logic                  access,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  nack,
    output logic                  i2c_SCL,
    inout  wire                   i2c_SDA
);

    localparam int Q   = quarter_cycles(CLK_FREQ, I2C_CLK_FREQ);
    localparam int SW  = BYTE_SIZE + DATA_WIDTH;
    localparam int BTW = (BYTE_SIZE > 2) ? $clog2(BYTE_SIZE) : 1;
    localparam int BYW = (NUM_BYTE > 0) ? $clog2(NUM_BYTE + 1) : 1;
    localparam logic [BTW-1:0] BIT_LAST  = BTW'(BYTE_SIZE - 1);
    localparam logic [BYW-1:0] BYTE_LAST = BYW'(NUM_BYTE);

    logic [2:0]     state_reg;
    logic [SW-1:0]  shift_reg;
    logic [BTW-1:0] bit_cnt_reg;
    logic [BYW-1:0] byte_cnt_reg;
    logic           stop_hold_reg;
    logic           busy_reg;
    logic           done_reg;
    logic           nack_reg;
    logic           scl_reg;
    logic           sda_low_reg;
    logic           scl_next;
    logic           sda_low_next;

    logic           tick;
    logic [1:0]     phase;
    logic           enable;
    logic           sda_in;
    logic           bit_end;

    assign enable  = (state_reg != ST_IDLE);
    assign sda_in  = i2c_SDA;
    assign bit_end = tick && (phase == PH_3);

    i2c_clk_gen #(
        .Q(Q)
    ) u_clk_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick),
        .phase  (phase)
    );

    // Transaction sequencing: request latch, bit/byte counting, ACK handling and the STOP tail
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            byte_cnt_reg  <= '0;
            stop_hold_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            nack_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        shift_reg <= {addr, access, wdata};
                        busy_reg  <= 1'b1;
                        nack_reg  <= 1'b0;
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_reg <= ST_ADDR;
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (bit_end) begin
                        // Shift after every bit, so the next byte's MSB is on top when ACK ends
                        shift_reg <= {shift_reg[SW-2:0], 1'b0};
                        if (bit_cnt_reg == BIT_LAST) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= ST_ACK;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BTW'(1);
                        end
                    end
                end
                ST_ACK: begin
                    if (bit_end) begin
                        if (sda_in) begin
                            nack_reg     <= 1'b1;
                            byte_cnt_reg <= '0;
                            state_reg    <= ST_STOP;
                        end else if (byte_cnt_reg == BYTE_LAST) begin
                            byte_cnt_reg <= '0;
                            state_reg    <= ST_STOP;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + BYW'(1);
                            state_reg    <= ST_DATA;
                        end
                    end
                end
                ST_STOP: begin
                    // One extra quarter of bus-free time follows the STOP edge
                    if (tick) begin
                        if (stop_hold_reg) begin
                            stop_hold_reg <= 1'b0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= ST_IDLE;
                        end else if (phase == PH_3) begin
                            stop_hold_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Pin levels for the current state and phase; SCL is high in phases 2 and 3
    always_comb begin
        scl_next     = 1'b1;
        sda_low_next = 1'b0;
        case (state_reg)
            ST_START: begin
                sda_low_next = phase[1];
            end
            ST_ADDR, ST_DATA: begin
                scl_next     = phase[1];
                sda_low_next = ~shift_reg[SW-1];
            end
            ST_ACK: begin
                scl_next = phase[1];
            end
            ST_STOP: begin
                if (!stop_hold_reg) begin
                    scl_next     = phase[1];
                    sda_low_next = (phase != PH_3);
                end
            end
            default: begin
                scl_next     = 1'b1;
                sda_low_next = 1'b0;
            end
        endcase
    end

    // Register the pin levels so SCL/SDA come straight from flops
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_reg     <= 1'b1;
            sda_low_reg <= 1'b0;
        end else begin
            scl_reg     <= scl_next;
            sda_low_reg <= sda_low_next;
        end
    end

    assign i2c_SCL = scl_reg;
    assign i2c_SDA = sda_low_reg ? 1'b0 : 1'bz;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign nack    = nack_reg;

endmodule

// File: tb/tb_i2c_master_write.sv
// Bench for i2c_master_write: slave bus-functional model with SDA pull-up,
// table-driven transactions, scoreboard of expected byte streams, plus
// hand-written sequences for busy-ignore, mid-transaction reset and back-to-back.
`timescale 1ns/1ps
module tb_i2c_master_write;

    localparam int CLK_FREQ     = 50;
    localparam int I2C_CLK_FREQ = 2500;
    localparam int NUM_BYTE     = 4;
    localparam int BYTE_SIZE    = 8;
    localparam int DATA_WIDTH   = 32;
    localparam int Q            = 5;      // 50*1000 / (2500*4)
    localparam int T            = 4 * Q;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        req    = 1'b0;
    logic [6:0]  addr   = '0;
    logic        access = 1'b0;
    logic [31:0] wdata  = '0;
    logic        busy, done, nack, scl;
    wire         sda;
    logic        bfm_low = 1'b0;

    assign sda = bfm_low ? 1'b0 : 1'bz;
    pullup(sda);

    always #5 clk = ~clk;

    i2c_master_write #(
        .CLK_FREQ     (CLK_FREQ),
        .I2C_CLK_FREQ (I2C_CLK_FREQ),
        .NUM_BYTE     (NUM_BYTE),
        .BYTE_SIZE    (BYTE_SIZE),
        .DATA_WIDTH   (DATA_WIDTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .addr    (addr),
        .access  (access),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .nack    (nack),
        .i2c_SCL (scl),
        .i2c_SDA (sda)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [6:0]  addr;
        logic        access;
        logic [31:0] wdata;
        int          nack_at;     // BFM byte index answered with NACK (0 = address), -1 none
        logic        exp_nack;
        int          exp_bytes;   // bytes seen on the bus, address byte included
    } vec_t;

    typedef struct packed {
        logic [39:0] stream;
        logic        exp_nack;
        logic [7:0]  exp_bytes;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // ---------------- slave bus-functional model ----------------
    int          bfm_nack_at = -1;
    int          bfm_clear_cnt = 0;
    int          bfm_clear_seen = 0;
    int          bfm_starts = 0, bfm_stops = 0, bfm_rises = 0;
    int          bfm_bit = 0, bfm_nbytes = 0;
    int          bfm_gap = 0, stop_cyc = 0;
    int          last_rise = 0, last_fall = 0;
    int          hi_min = 1000000, hi_max = 0, lo_min = 1000000, lo_max = 0;
    logic        bfm_active = 0, bfm_in_ack = 0, bfm_ack_pend = 0;
    logic        seen_rise = 0, seen_fall = 0;
    logic        p_scl = 1'b1, p_sda = 1'b1;
    logic [7:0]  bfm_sh = '0;
    logic [7:0]  bfm_rx [0:7];

    initial begin
        forever begin
            @(negedge clk);
            if (bfm_clear_cnt != bfm_clear_seen) begin
                bfm_clear_seen = bfm_clear_cnt;
                bfm_low = 1'b0; bfm_active = 0; bfm_in_ack = 0; bfm_ack_pend = 0; bfm_bit = 0;
            end else begin
                if (p_scl && scl && p_sda && !sda) begin
                    bfm_starts++; bfm_active = 1; bfm_bit = 0; bfm_nbytes = 0;
                    bfm_in_ack = 0; bfm_ack_pend = 0; seen_rise = 0; seen_fall = 0;
                    hi_min = 1000000; hi_max = 0; lo_min = 1000000; lo_max = 0;
                    bfm_gap = cyc - stop_cyc;
                end else if (p_scl && scl && !p_sda && sda) begin
                    bfm_stops++; bfm_active = 0; stop_cyc = cyc;
                end
                if (!p_scl && scl) begin
                    bfm_rises++;
                    if (bfm_active) begin
                        if (seen_fall) begin
                            if (cyc - last_fall < lo_min) lo_min = cyc - last_fall;
                            if (cyc - last_fall > lo_max) lo_max = cyc - last_fall;
                        end
                        seen_rise = 1; last_rise = cyc;
                        if (!bfm_in_ack) begin
                            bfm_sh = {bfm_sh[6:0], sda};
                            bfm_bit++;
                            if (bfm_bit == 8) begin
                                if (bfm_nbytes < 8) bfm_rx[bfm_nbytes] = bfm_sh;
                                bfm_nbytes++; bfm_bit = 0; bfm_ack_pend = 1;
                            end
                        end
                    end
                end
                if (p_scl && !scl && bfm_active) begin
                    if (seen_rise) begin
                        if (cyc - last_rise < hi_min) hi_min = cyc - last_rise;
                        if (cyc - last_rise > hi_max) hi_max = cyc - last_rise;
                    end
                    seen_fall = 1; last_fall = cyc;
                    if (bfm_ack_pend) begin
                        bfm_ack_pend = 0; bfm_in_ack = 1;
                        bfm_low = (bfm_nbytes - 1 != bfm_nack_at);
                    end else if (bfm_in_ack) begin
                        bfm_in_ack = 0; bfm_low = 1'b0;
                    end
                end
            end
            p_scl = scl;
            p_sda = sda;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ge(input string name, input longint act, input longint lim);
        n_cmp++;
        if (act < lim) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected at least %0d", name, act, lim);
        end
    endtask

    int req_cyc = 0, snap_starts = 0, snap_stops = 0, snap_rises = 0;

    // Drive one request pulse (caller is at a negedge) and record the expectation
    task automatic start_txn(input vec_t v);
        exp_t e;
        addr = v.addr; access = v.access; wdata = v.wdata;
        bfm_nack_at = v.nack_at;
        req = 1'b1;
        req_cyc = cyc;
        snap_starts = bfm_starts; snap_stops = bfm_stops; snap_rises = bfm_rises;
        e.stream = {v.addr, v.access, v.wdata};
        e.exp_nack = v.exp_nack;
        e.exp_bytes = 8'(v.exp_bytes);
        sb_q.push_back(e);
        @(negedge clk);
        req = 1'b0;
        check("busy_after_req", busy, 1);
    endtask

    // Wait (bounded) for done, pop the expectation and compare everything the BFM saw
    task automatic finish_txn(input string tag);
        exp_t e;
        int   lat;
        int   nb;
        bit   got = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            check({tag, "_done_timeout"}, 0, 1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        lat = cyc - req_cyc;
        if (sb_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 0, 1);
            return;
        end
        e = sb_q.pop_front();
        nb = int'(e.exp_bytes);
        check({tag, "_nack"}, nack, e.exp_nack);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_latency"}, lat, T * (2 + 9 * nb) + Q + 1);
        check({tag, "_nbytes"}, bfm_nbytes, nb);
        for (int i = 0; i < nb && i < 8; i++)
            check($sformatf("%s_byte%0d", tag, i), bfm_rx[i], e.stream[39 - 8*i -: 8]);
        check({tag, "_starts"}, bfm_starts - snap_starts, 1);
        check({tag, "_stops"}, bfm_stops - snap_stops, 1);
        check({tag, "_scl_pulses"}, bfm_rises - snap_rises, 9 * nb + 1);
        check({tag, "_scl_high_min"}, hi_min, 2 * Q);
        check({tag, "_scl_high_max"}, hi_max, 2 * Q);
        check({tag, "_scl_low_min"}, lo_min, 2 * Q);
        check({tag, "_scl_low_max"}, lo_max, 2 * Q);
        $display("txn %s: stream=0x%010h bytes=%0d nack=%0b latency=%0d", tag, e.stream, bfm_nbytes, nack, lat);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    // Global time bound so the run always ends
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl [0:4];
    vec_t v;

    initial begin
        tbl[0] = '{7'h5A, 1'b0, 32'hDEADBEEF, -1, 1'b0, 5};
        tbl[1] = '{7'h12, 1'b1, 32'h01234567, -1, 1'b0, 5};
        tbl[2] = '{7'h7F, 1'b0, 32'hA5A55A5A,  3, 1'b1, 4};
        tbl[3] = '{7'h00, 1'b0, 32'hCAFEF00D,  0, 1'b1, 1};
        tbl[4] = '{7'h33, 1'b0, 32'h12345678,  4, 1'b1, 5};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_scl", scl, 1);
        check("reset_sda", sda, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_nack", nack, 0);

        // Table-driven transactions, including NACK on address, middle and last byte
        for (int i = 0; i < 5; i++) begin
            start_txn(tbl[i]);
            finish_txn($sformatf("tbl%0d", i));
            repeat (3) @(negedge clk);
        end

        // A second req while busy is ignored
        v = '{7'h21, 1'b0, 32'h13579BDF, -1, 1'b0, 5};
        start_txn(v);
        repeat (150) @(negedge clk);
        addr = 7'h44; wdata = 32'h0; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        finish_txn("busy_ignore");
        repeat (3 * T) @(negedge clk);
        check("busy_ignore_no_extra_start", bfm_starts - snap_starts, 1);
        check("busy_ignore_idle_after", busy, 0);

        // Reset pulse in the middle of the first data byte
        v = '{7'h55, 1'b0, 32'hF0F00F0F, -1, 1'b0, 5};
        start_txn(v);
        repeat (12 * T + 1) @(negedge clk);
        reset = 1'b1;
        bfm_clear_cnt++;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_scl", scl, 1);
        check("midreset_sda", sda, 1);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_nack", nack, 0);
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        repeat (5) @(negedge clk);
        v = '{7'h2B, 1'b0, 32'h89ABCDEF, -1, 1'b0, 5};
        start_txn(v);
        finish_txn("after_reset");
        repeat (3) @(negedge clk);

        // Back-to-back: second req in the cycle right after done
        v = '{7'h0F, 1'b0, 32'h00000000, -1, 1'b0, 5};
        start_txn(v);
        finish_txn("b2b_zero");
        v = '{7'h70, 1'b0, 32'hFFFFFFFF, -1, 1'b0, 5};
        start_txn(v);
        finish_txn("b2b_ones");
        check_ge("b2b_bus_free_gap", bfm_gap, Q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
